// File: rtl/mem_read_data_decoder.sv
// Load-side data decoder: issues one read strobe, waits READ_LATENCY cycles, then
// extracts and extends the addressed byte/halfword/word (big-endian lanes, lane 0 = MSB).
module mem_read_data_decoder #(
  parameter int READ_LATENCY = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  addr_offset,
  input  logic [1:0]  data_size,
  input  logic        sign_ext,
  output logic        mem_rd_en,
  input  logic [31:0] mem_rdata,
  output logic        resp_valid,
  output logic [31:0] resp_data,
  output logic        misaligned,
  output logic        busy
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  localparam logic [1:0] SZ_WORD = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_BYTE = 2'b10;
  localparam logic [1:0] CNT_INIT = 2'(READ_LATENCY - 1);

  state_t      state_q, state_d;
  logic [1:0]  off_q, size_q, cnt_q;
  logic        sext_q, err_q;
  logic        req_legal, accept, sample;
  logic [31:0] extracted;

  assign req_legal = (data_size == SZ_WORD && addr_offset == 2'b00) ||
                     (data_size == SZ_HALF && addr_offset[0] == 1'b0) ||
                     (data_size == SZ_BYTE);
  assign accept    = (state_q == S_IDLE) && req_valid;
  assign sample    = (state_q == S_WAIT) && (cnt_q == 2'd0);

  // Outputs decode straight from the state register so reset clears them asynchronously.
  assign req_ready  = (state_q == S_IDLE);
  assign busy       = (state_q != S_IDLE);
  assign mem_rd_en  = (state_q == S_ISSUE);
  assign resp_valid = (state_q == S_RESP);
  assign misaligned = (state_q == S_RESP) && err_q;

  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // NOTE: default assignment first; any path leaving state_d unassigned would infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (req_valid) state_d = req_legal ? S_ISSUE : S_RESP;
      S_ISSUE: state_d = S_WAIT;
      S_WAIT:  if (cnt_q == 2'd0) state_d = S_RESP;
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      off_q     <= 2'b00;
      size_q    <= 2'b00;
      sext_q    <= 1'b0;
      err_q     <= 1'b0;
      cnt_q     <= 2'd0;
      resp_data <= 32'h0;
    end else begin
      if (accept) begin
        off_q  <= addr_offset;
        size_q <= data_size;
        sext_q <= sign_ext;
        err_q  <= !req_legal;
        if (!req_legal) resp_data <= 32'h0;
      end
      if (state_q == S_ISSUE)                 cnt_q <= CNT_INIT;
      else if (state_q == S_WAIT && cnt_q != 2'd0) cnt_q <= cnt_q - 2'd1;
      if (sample) resp_data <= extracted;
    end
  end

  // Lane select mirrors the store encoder: offset 0 is the most significant byte.
  logic [7:0]  lane_b;
  logic [15:0] lane_h;
  always_comb begin
    lane_b    = 8'h0;
    lane_h    = off_q[1] ? mem_rdata[15:0] : mem_rdata[31:16];
    extracted = 32'h0;
    unique case (off_q)
      2'd0: lane_b = mem_rdata[31:24];
      2'd1: lane_b = mem_rdata[23:16];
      2'd2: lane_b = mem_rdata[15:8];
      2'd3: lane_b = mem_rdata[7:0];
      default: lane_b = 8'h0;
    endcase
    unique case (size_q)
      SZ_WORD: extracted = mem_rdata;
      SZ_HALF: extracted = {{16{sext_q & lane_h[15]}}, lane_h};
      SZ_BYTE: extracted = {{24{sext_q & lane_b[7]}}, lane_b};
      default: extracted = 32'h0;
    endcase
  end

endmodule

// File: tb/tb_mem_read_data_decoder.sv
// Bench for mem_read_data_decoder: a READ_LATENCY=1 and a READ_LATENCY=3 instance,
// table-driven vectors on both plus directed latency, hold-off and reset sequences.
module tb_mem_read_data_decoder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  addr_offset, data_size;
  logic        sign_ext;

  logic        req_valid1, req_ready1, mem_rd_en1, resp_valid1, misaligned1, busy1;
  logic [31:0] mem_rdata1, resp_data1;
  logic        req_valid3, req_ready3, mem_rd_en3, resp_valid3, misaligned3, busy3;
  logic [31:0] mem_rdata3, resp_data3;

  always #5 clk = ~clk;

  mem_read_data_decoder #(.READ_LATENCY(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid1), .req_ready(req_ready1),
    .addr_offset(addr_offset), .data_size(data_size), .sign_ext(sign_ext),
    .mem_rd_en(mem_rd_en1), .mem_rdata(mem_rdata1), .resp_valid(resp_valid1),
    .resp_data(resp_data1), .misaligned(misaligned1), .busy(busy1));

  mem_read_data_decoder #(.READ_LATENCY(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid3), .req_ready(req_ready3),
    .addr_offset(addr_offset), .data_size(data_size), .sign_ext(sign_ext),
    .mem_rd_en(mem_rd_en3), .mem_rdata(mem_rdata3), .resp_valid(resp_valid3),
    .resp_data(resp_data3), .misaligned(misaligned3), .busy(busy3));

  // Observation mux so one task can drive and watch either instance.
  bit          sel3;
  logic        o_ready, o_rd_en, o_resp, o_mis, o_busy;
  logic [31:0] o_data;
  always_comb begin
    o_ready = sel3 ? req_ready3  : req_ready1;
    o_rd_en = sel3 ? mem_rd_en3  : mem_rd_en1;
    o_resp  = sel3 ? resp_valid3 : resp_valid1;
    o_mis   = sel3 ? misaligned3 : misaligned1;
    o_busy  = sel3 ? busy3       : busy1;
    o_data  = sel3 ? resp_data3  : resp_data1;
  end

  typedef struct {
    logic [1:0]  size;
    logic [1:0]  off;
    logic        sext;
    logic [31:0] rdata;
    logic [31:0] exp_data;
    logic        exp_err;
  } vec_t;

  vec_t vecs[11];
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " dut1 ready"},    32'(req_ready1),  32'd1);
    check({tag, " dut1 rd_en"},    32'(mem_rd_en1),  32'd0);
    check({tag, " dut1 resp"},     32'(resp_valid1), 32'd0);
    check({tag, " dut1 mis"},      32'(misaligned1), 32'd0);
    check({tag, " dut1 busy"},     32'(busy1),       32'd0);
    check({tag, " dut1 data"},     resp_data1,       32'h0);
    check({tag, " dut3 ready"},    32'(req_ready3),  32'd1);
    check({tag, " dut3 rd_en"},    32'(mem_rd_en3),  32'd0);
    check({tag, " dut3 resp"},     32'(resp_valid3), 32'd0);
    check({tag, " dut3 mis"},      32'(misaligned3), 32'd0);
    check({tag, " dut3 busy"},     32'(busy3),       32'd0);
    check({tag, " dut3 data"},     resp_data3,       32'h0);
  endtask

  // One request on the selected instance; cycle k counts clock periods after the accept edge.
  task automatic run_vec(input int idx, input bit use3);
    vec_t v = vecs[idx];
    int rd_cnt = 0, rd_cyc = 0, rsp_cyc = 0, rsp_cnt = 0, stray_mis = 0;
    logic [31:0] data = 32'hx;
    logic        err  = 1'bx;
    string tag = $sformatf("L%0d vec%0d", use3 ? 3 : 1, idx);
    sel3 = use3;
    @(negedge clk);
    check({tag, " ready before"}, 32'(o_ready), 32'd1);
    addr_offset = v.off;
    data_size   = v.size;
    sign_ext    = v.sext;
    mem_rdata1  = v.rdata;
    mem_rdata3  = v.rdata;
    if (use3) req_valid3 = 1'b1; else req_valid1 = 1'b1;
    @(posedge clk);
    #1 req_valid1 = 1'b0;
    req_valid3 = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (o_rd_en) begin
        rd_cnt++;
        if (rd_cyc == 0) rd_cyc = k;
      end
      if (o_resp) begin
        rsp_cnt++;
        if (rsp_cyc == 0) begin
          rsp_cyc = k;
          data    = o_data;
          err     = o_mis;
        end
      end else if (o_mis) stray_mis++;
    end
    check({tag, " rd_en pulses"}, 32'(rd_cnt), v.exp_err ? 32'd0 : 32'd1);
    check({tag, " rd_en cycle"},  32'(rd_cyc), v.exp_err ? 32'd0 : 32'd1);
    check({tag, " resp pulses"},  32'(rsp_cnt), 32'd1);
    check({tag, " resp cycle"},   32'(rsp_cyc), v.exp_err ? 32'd1 : (use3 ? 32'd5 : 32'd3));
    check({tag, " resp_data"},    data, v.exp_data);
    check({tag, " misaligned"},   32'(err), 32'(v.exp_err));
    check({tag, " stray mis"},    32'(stray_mis), 32'd0);
    check({tag, " data held"},    o_data, v.exp_data);
    check({tag, " idle after"},   32'(o_busy), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int rd1, rd2, rsp1, rsp2, ready_hi_early, ready6, stray_resp;
    logic [31:0] d1, d2;

    //            size   off   sext  rdata          expected       err
    vecs[0]  = '{2'b00, 2'd0, 1'b0, 32'hDEADBEEF, 32'hDEADBEEF, 1'b0};
    vecs[1]  = '{2'b10, 2'd3, 1'b1, 32'h12345680, 32'hFFFFFF80, 1'b0};
    vecs[2]  = '{2'b10, 2'd3, 1'b0, 32'h12345680, 32'h00000080, 1'b0};
    vecs[3]  = '{2'b01, 2'd1, 1'b0, 32'h1234F00D, 32'h00000000, 1'b1};
    vecs[4]  = '{2'b01, 2'd2, 1'b0, 32'h1234F00D, 32'h0000F00D, 1'b0};
    vecs[5]  = '{2'b01, 2'd0, 1'b1, 32'h1234F00D, 32'h00001234, 1'b0};
    vecs[6]  = '{2'b00, 2'd2, 1'b0, 32'hCAFEBABE, 32'h00000000, 1'b1};
    vecs[7]  = '{2'b10, 2'd0, 1'b1, 32'h81234567, 32'hFFFFFF81, 1'b0};
    vecs[8]  = '{2'b11, 2'd0, 1'b0, 32'hCAFEBABE, 32'h00000000, 1'b1};
    vecs[9]  = '{2'b01, 2'd0, 1'b1, 32'h80010000, 32'hFFFF8001, 1'b0};
    vecs[10] = '{2'b00, 2'd0, 1'b1, 32'h89ABCDEF, 32'h89ABCDEF, 1'b0};

    rst_n = 1'b0;
    req_valid1 = 1'b0; req_valid3 = 1'b0;
    addr_offset = 2'd0; data_size = 2'd0; sign_ext = 1'b0;
    mem_rdata1 = 32'h0; mem_rdata3 = 32'h0;
    sel3 = 1'b0;
    #1 check_reset_outputs("reset");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 11; i++) run_vec(i, 1'b0);
    for (int i = 0; i < 11; i++) run_vec(i, 1'b1);

    // L=3 with garbage outside the sample cycle and req_valid held high across two requests.
    sel3 = 1'b1;
    rd1 = 0; rd2 = 0; rsp1 = 0; rsp2 = 0; ready_hi_early = 0; ready6 = 0; stray_resp = 0;
    d1 = 32'hx; d2 = 32'hx;
    @(negedge clk);
    addr_offset = 2'd1; data_size = 2'b10; sign_ext = 1'b1;
    mem_rdata3 = 32'h12345678;
    req_valid3 = 1'b1;
    @(posedge clk);
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (mem_rd_en3) begin
        if (rd1 == 0) rd1 = k; else if (rd2 == 0) rd2 = k;
      end
      if (resp_valid3) begin
        if (rsp1 == 0) begin rsp1 = k; d1 = resp_data3; end
        else if (rsp2 == 0) begin rsp2 = k; d2 = resp_data3; end
        else stray_resp++;
      end
      if (k <= 5 && req_ready3) ready_hi_early++;
      if (k == 6) ready6 = int'(req_ready3);
      mem_rdata3 = (k == 4) ? 32'h00A50000 : 32'h12345678;
      if (k == 7) req_valid3 = 1'b0;
    end
    check("hold rd_en first",   32'(rd1),  32'd1);
    check("hold rd_en second",  32'(rd2),  32'd7);
    check("hold resp1 cycle",   32'(rsp1), 32'd5);
    check("hold resp1 data",    d1,        32'hFFFFFFA5);
    check("hold ready low",     32'(ready_hi_early), 32'd0);
    check("hold ready cycle6",  32'(ready6), 32'd1);
    check("hold resp2 cycle",   32'(rsp2), 32'd11);
    check("hold resp2 data",    d2,        32'h00000034);
    check("hold stray resp",    32'(stray_resp), 32'd0);

    // Reset while dut3 is in WAIT and dut1 is strobing mem_rd_en.
    @(negedge clk);
    addr_offset = 2'd0; data_size = 2'b10; sign_ext = 1'b0;
    mem_rdata1 = 32'h11223344; mem_rdata3 = 32'h11223344;
    req_valid3 = 1'b1;
    @(posedge clk);
    #1 req_valid3 = 1'b0;
    req_valid1 = 1'b1;
    @(posedge clk);
    #1 req_valid1 = 1'b0;
    #2 check("pre-reset dut1 rd_en", 32'(mem_rd_en1), 32'd1);
    check("pre-reset dut3 busy", 32'(busy3), 32'd1);
    rst_n = 1'b0;
    #1 check_reset_outputs("async reset");
    stray_resp = 0;
    repeat (4) begin
      @(negedge clk);
      if (resp_valid1 || resp_valid3) stray_resp++;
    end
    check("reset no resp", 32'(stray_resp), 32'd0);
    rst_n = 1'b1;
    run_vec(1, 1'b0);
    run_vec(5, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
